// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the DLX pipeline (master) and hazard_ctrl (slave).
// Carries hazard sources from ID/EX/MEM and the per-stage enables/flushes back.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       IFID_rs;
    logic [4:0]       IFID_rt;
    logic             IFID_uses_rt;
    logic [4:0]       IDEX_rt;
    logic             IDEX_MemRead;
    logic             branch_taken;
    logic             md_start;
    logic             md_done;
    logic             mem_busy;

    logic             PC_write;
    logic             IFID_write;
    logic             IDEX_write;
    logic             EXMEM_write;
    logic             MEMWB_write;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             EXMEM_flush;
    logic             md_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output IFID_rs, IFID_rt, IFID_uses_rt, IDEX_rt, IDEX_MemRead,
        output branch_taken, md_start, md_done, mem_busy,
        input  PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
        input  IFID_flush, IDEX_flush, EXMEM_flush, md_err, stall_cycles
    );

    modport slave (
        input  IFID_rs, IFID_rt, IFID_uses_rt, IDEX_rt, IDEX_MemRead,
        input  branch_taken, md_start, md_done, mem_busy,
        output PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
        output IFID_flush, IDEX_flush, EXMEM_flush, md_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// DLX 5-stage pipeline sequencer: load-use stall, branch squash, memory freeze, MUL/DIV wait.
// Define HAZARD_STATS_EN to build the saturating stall_cycles counter; otherwise it reads 0.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 16
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned MdCntW = $clog2(MD_TIMEOUT + 1);
    localparam logic [MdCntW-1:0] MdLast = MdCntW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMdWait  = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    state_e              eff_state;
    logic [MdCntW-1:0]   md_cnt_q, md_cnt_d;
    logic                load_use;

    logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic ifid_flush, idex_flush, exmem_flush, md_err;

    assign load_use = bus.IDEX_MemRead && (bus.IDEX_rt != 5'd0) &&
                      ((bus.IDEX_rt == bus.IFID_rs) ||
                       (bus.IFID_uses_rt && (bus.IDEX_rt == bus.IFID_rt)));

    // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
    assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_err      = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        md_cnt_d    = md_cnt_q;

        if (bus.mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            state_d     = StMemWait;
            if (state_q != StMemWait) begin
                ret_d = state_q;
            end
        end else begin
            state_d = eff_state;
            case (eff_state)
                StMdWait: begin
                    md_cnt_d = md_cnt_q + 1'b1;
                    if (bus.md_done) begin
                        state_d = StRun;
                    end else if (md_cnt_q == MdLast) begin
                        md_err  = 1'b1;
                        state_d = StRun;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                    end
                end
                default: begin
                    // A taken branch squashes the dependent instruction, so no stall is needed.
                    if (bus.branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                    if (bus.md_start) begin
                        state_d  = StMdWait;
                        md_cnt_d = '0;
                    end
                end
            endcase
        end

        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            md_err      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            ret_q    <= StRun;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign bus.PC_write    = pc_write;
    assign bus.IFID_write  = ifid_write;
    assign bus.IDEX_write  = idex_write;
    assign bus.EXMEM_write = exmem_write;
    assign bus.MEMWB_write = memwb_write;
    assign bus.IFID_flush  = ifid_flush;
    assign bus.IDEX_flush  = idex_flush;
    assign bus.EXMEM_flush = exmem_flush;
    assign bus.md_err      = md_err;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

    a_md_err_single : assert property (@(posedge clk) disable iff (!rst_n)
        md_err |=> !md_err);
    a_ret_legal : assert property (@(posedge clk) disable iff (!rst_n)
        ret_q != StMemWait);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_TIMEOUT=8 and a 5-bit stall counter.
module tb_hazard_ctrl;

    localparam int unsigned CntW = 5;
`ifdef HAZARD_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    // {PC, IFID_w, IDEX_w, EXMEM_w, MEMWB_w, IFID_f, IDEX_f, EXMEM_f, md_err}
    localparam logic [8:0] Norm = 9'b11111_000_0;
    localparam logic [8:0] Lu   = 9'b00111_010_0;
    localparam logic [8:0] Br   = 9'b11111_110_0;
    localparam logic [8:0] Mdw  = 9'b00011_001_0;
    localparam logic [8:0] Frz  = 9'b00000_000_0;
    localparam logic [8:0] Rst  = 9'b00000_111_0;
    localparam logic [8:0] Err  = 9'b11111_000_1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    logic [8:0] obs;

    hazard_ctrl_if #(.CNT_W(CntW)) bus ();

    hazard_ctrl #(
        .MD_TIMEOUT(8),
        .CNT_W     (CntW)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.EXMEM_write,
                  bus.MEMWB_write, bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush, bus.md_err};

    function automatic logic [CntW-1:0] exp_sc();
        if (!Stats) return '0;
        return (exp_stall > 31) ? 5'd31 : CntW'(exp_stall);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.IFID_rs      = 5'd0;
        bus.IFID_rt      = 5'd0;
        bus.IFID_uses_rt = 1'b0;
        bus.IDEX_rt      = 5'd0;
        bus.IDEX_MemRead = 1'b0;
        bus.branch_taken = 1'b0;
        bus.md_start     = 1'b0;
        bus.md_done      = 1'b0;
        bus.mem_busy     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== Rst) begin
            errors++; $display("FAIL reset_out: got %b want %b", obs, Rst);
        end
        checks++;
        if (bus.stall_cycles !== 5'd0) begin
            errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL reset_release: got %b want %b", obs, Norm);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive_idle();
        bus.IDEX_MemRead = 1'b1; bus.IDEX_rt = 5'd5; bus.IFID_rs = 5'd5;
        #1; checks++;
        if (obs !== Lu) begin
            errors++; $display("FAIL lu_rs: got %b want %b", obs, Lu);
        end
        exp_stall++; tick();
        drive_idle();
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL lu_one_cycle: got %b want %b", obs, Norm);
        end
        tick();
        bus.IDEX_MemRead = 1'b1; bus.IDEX_rt = 5'd0; bus.IFID_rs = 5'd0;
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL lu_r0: got %b want %b", obs, Norm);
        end
        tick();
        bus.IDEX_rt = 5'd5; bus.IFID_rs = 5'd3; bus.IFID_rt = 5'd5; bus.IFID_uses_rt = 1'b0;
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL lu_rt_unused: got %b want %b", obs, Norm);
        end
        tick();
        bus.IFID_uses_rt = 1'b1;
        #1; checks++;
        if (obs !== Lu) begin
            errors++; $display("FAIL lu_rt_used: got %b want %b", obs, Lu);
        end
        exp_stall++; tick();
        drive_idle();
        #1; checks++;
        if (bus.stall_cycles !== exp_sc()) begin
            errors++; $display("FAIL lu_stall: got %0d want %0d", bus.stall_cycles, exp_sc());
        end
    endtask

    task automatic test_branch_lu();
        drive_idle();
        bus.IDEX_MemRead = 1'b1; bus.IDEX_rt = 5'd7; bus.IFID_rs = 5'd7;
        bus.branch_taken = 1'b1;
        #1; checks++;
        if (obs !== Br) begin
            errors++; $display("FAIL branch_lu: got %b want %b", obs, Br);
        end
        tick();
        drive_idle();
        #1; checks++;
        if (obs !== Norm || bus.stall_cycles !== exp_sc()) begin
            errors++;
            $display("FAIL branch_after: got %b/%0d want %b/%0d", obs, bus.stall_cycles,
                     Norm, exp_sc());
        end
        tick();
    endtask

    task automatic test_md();
        drive_idle();
        bus.md_start = 1'b1;
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL md_start: got %b want %b", obs, Norm);
        end
        tick();
        bus.md_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1; checks++;
            if (obs !== Mdw) begin
                errors++; $display("FAIL md_wait%0d: got %b want %b", i, obs, Mdw);
            end
            exp_stall++; tick();
        end
        bus.md_done = 1'b1;
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL md_done: got %b want %b", obs, Norm);
        end
        tick();
        bus.md_done = 1'b0;
        #1; checks++;
        if (obs !== Norm || bus.stall_cycles !== exp_sc()) begin
            errors++;
            $display("FAIL md_after: got %b/%0d want %b/%0d", obs, bus.stall_cycles,
                     Norm, exp_sc());
        end
        tick();
    endtask

    task automatic test_md_freeze();
        logic [8:0] want [8];
        want = '{Norm, Mdw, Mdw, Frz, Frz, Mdw, Mdw, Norm};
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            bus.md_start = (i == 0);
            bus.mem_busy = (i == 3 || i == 4);
            bus.md_done  = (i == 7);
            #1; checks++;
            if (obs !== want[i]) begin
                errors++; $display("FAIL md_freeze%0d: got %b want %b", i, obs, want[i]);
            end
            if (i >= 1 && i <= 6) exp_stall++;
            tick();
        end
        drive_idle();
        #1; checks++;
        if (obs !== Norm || bus.stall_cycles !== exp_sc()) begin
            errors++;
            $display("FAIL md_freeze_end: got %b/%0d want %b/%0d", obs, bus.stall_cycles,
                     Norm, exp_sc());
        end
        tick();
    endtask

    // freeze_at < 0 disables the freeze; frozen cycles must not advance the timeout.
    task automatic test_timeout(input int freeze_at);
        int mdc;
        drive_idle();
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        mdc = 0;
        for (int i = 0; i < 14 && mdc < 8; i++) begin
            bus.mem_busy = (freeze_at >= 0 && i >= freeze_at && i < freeze_at + 3);
            #1; checks++;
            if (bus.mem_busy) begin
                if (obs !== Frz) begin
                    errors++; $display("FAIL to_frz%0d: got %b want %b", i, obs, Frz);
                end
            end else begin
                mdc++;
                if (obs !== ((mdc == 8) ? Err : Mdw)) begin
                    errors++;
                    $display("FAIL to_wait%0d: got %b want %b", mdc, obs,
                             (mdc == 8) ? Err : Mdw);
                end
            end
            if (mdc < 8) exp_stall++;
            tick();
        end
        drive_idle();
        #1; checks++;
        if (obs !== Norm || bus.stall_cycles !== exp_sc()) begin
            errors++;
            $display("FAIL to_after: got %b/%0d want %b/%0d", obs, bus.stall_cycles,
                     Norm, exp_sc());
        end
        tick();
    endtask

    task automatic test_saturate();
        drive_idle();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1; checks++;
            if (obs !== Frz) begin
                errors++; $display("FAIL sat_frz%0d: got %b want %b", i, obs, Frz);
            end
            exp_stall++; tick();
        end
        bus.mem_busy = 1'b0;
        bus.IDEX_MemRead = 1'b1; bus.IDEX_rt = 5'd9; bus.IFID_rs = 5'd9;
        #1; checks++;
        if (obs !== Lu) begin
            errors++; $display("FAIL sat_resume_lu: got %b want %b", obs, Lu);
        end
        exp_stall++; tick();
        drive_idle();
        #1; checks++;
        if (bus.stall_cycles !== exp_sc()) begin
            errors++; $display("FAIL sat_value: got %0d want %0d", bus.stall_cycles, exp_sc());
        end
        tick();
    endtask

    task automatic test_reset_mid_md();
        drive_idle();
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        #1; checks++;
        if (obs !== Mdw) begin
            errors++; $display("FAIL rmd_wait: got %b want %b", obs, Mdw);
        end
        tick();
        rst_n = 1'b0;
        #1; checks++;
        if (obs !== Rst) begin
            errors++; $display("FAIL rmd_forced: got %b want %b", obs, Rst);
        end
        exp_stall = 0;
        tick();
        rst_n = 1'b1;
        bus.md_done = 1'b1;
        #1; checks++;
        if (obs !== Norm || bus.stall_cycles !== 5'd0) begin
            errors++;
            $display("FAIL rmd_release: got %b/%0d want %b/0", obs, bus.stall_cycles, Norm);
        end
        tick();
        bus.md_done = 1'b0;
        #1; checks++;
        if (obs !== Norm) begin
            errors++; $display("FAIL rmd_run: got %b want %b", obs, Norm);
        end
        tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_use();
        test_branch_lu();
        test_md();
        test_md_freeze();
        test_timeout(-1);
        test_timeout(3);
        test_saturate();
        test_reset_mid_md();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the 5-stage DLX core; sits beside the forwarding unit.
- Generates per-stage pipeline-register write enables and flushes for four cases: load-use stalls, taken-branch squash, data-memory wait freeze, and multi-cycle multiply/divide occupancy of EX.
- A small FSM remembers long-latency conditions across cycles; single-cycle hazards are decoded combinationally.

## Interface
Parameters:
- MD_TIMEOUT, 64, maximum cycles spent in MD_WAIT before forced abort (≥2).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- IFID_rs, IFID_rt  in  5 each  source registers of the instruction in ID.
- IFID_uses_rt  in  1  ID instruction reads rt as an operand (not as a destination).
- IDEX_rt  in  5  destination of the instruction in EX when it is a load.
- IDEX_MemRead  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- md_start  in  1  multi-cycle MUL/DIV entered EX this cycle.
- md_done  in  1  MUL/DIV result is valid this cycle.
- mem_busy  in  1  data memory is not ready; MEM stage must hold.
- PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write  out  1 each  register load enables.
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  load a bubble (NOP) instead of data.
- md_err  out  1  one-cycle pulse on MD timeout.
- stall_cycles  out  CNT_W  stall statistics counter; see Configuration.

## Operation
- FSM states: RUN, MD_WAIT, MEM_WAIT. Registered `ret` (RUN or MD_WAIT) records the state to resume after MEM_WAIT.
- Timeout counter `md_cnt` is ceil(log2(MD_TIMEOUT+1)) bits wide.
- Priority, highest first: mem_busy > MD_WAIT > branch_taken > load-use. Default is all *_write=1 and all *_flush=0.
- **mem_busy=1 (any state)**
  - All five *_write=0 and all flushes=0; the whole pipeline freezes.
  - Next state is MEM_WAIT. `ret` is loaded only when entering from RUN or MD_WAIT.
  - md_cnt holds.
- **MEM_WAIT with mem_busy=0**
  - Outputs are those of state `ret` evaluated this cycle.
  - Next state is `ret`.
- **RUN with md_start**
  - Normal outputs this cycle.
  - Next state is MD_WAIT; md_cnt=0.
- **MD_WAIT**
  - PC_write=IFID_write=IDEX_write=0, EXMEM_flush=1; MEM and WB advance.
  - md_cnt increments each cycle.
  - On md_done=1: RUN outputs this cycle (result enters EX/MEM); next state is RUN.
  - If md_cnt reaches MD_TIMEOUT−1 without md_done: md_err=1 this cycle, RUN outputs, next state is RUN.
- **branch_taken in RUN**
  - IFID_flush=1, IDEX_flush=1, PC_write=1 (target loaded).
  - A coincident load-use condition is ignored because the dependent instruction is squashed.
- **Load-use in RUN**
  - Condition: IDEX_MemRead && IDEX_rt≠0 && (IDEX_rt==IFID_rs || (IFID_uses_rt && IDEX_rt==IFID_rt)).
  - Response: PC_write=0, IFID_write=0, IDEX_flush=1 for exactly that cycle. No state change.
- **Ignored inputs**
  - md_start outside RUN is ignored.
  - md_done outside MD_WAIT is ignored.

## Timing
- All outputs are combinational from (state, ret, md_cnt, inputs); zero-cycle latency.
- State, ret, md_cnt and stall_cycles update on the rising clk edge.
- Reset (rst_n=0, asynchronous, any state including mid-MD_WAIT or MEM_WAIT):
  - state=RUN, ret=RUN, md_cnt=0, stall_cycles=0.
  - Outputs forced: all *_write=0, IFID_flush=IDEX_flush=EXMEM_flush=1, md_err=0.
  - First normal output occurs in the cycle after rst_n rises.
- Load-use penalty is 1 cycle; taken-branch penalty is 2 bubbles; MD occupancy is (cycles until md_done).
- A freeze during MD_WAIT extends wall-clock time but not the timeout count.
- md_err is never asserted for two consecutive cycles.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cycles increments on every clock with rst_n=1 and PC_write=0.
  - It saturates at 2^CNT_W−1 and never wraps.
- HAZARD_STATS_EN undefined:
  - The port remains; stall_cycles is constant 0 and no counter flops are built.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_rt=5, IFID_rs=5 → one cycle with PC_write=0, IFID_write=0, IDEX_flush=1. Repeat with IDEX_rt=0 → no stall. Repeat with IFID_rt=5 and IFID_uses_rt=0 → no stall.
- Branch plus load-use in the same cycle → IFID_flush=IDEX_flush=1, PC_write=1, no stall. stall_cycles is unchanged with HAZARD_STATS_EN.
- md_start, then md_done 4 cycles later → MD_WAIT outputs (PC_write=0, EXMEM_flush=1) for cycles 1–3 and RUN outputs on the md_done cycle. With HAZARD_STATS_EN, stall_cycles=3.
- MD_WAIT with mem_busy=1 for 2 cycles mid-wait → all writes 0 and flushes 0 during the freeze, then resume MD_WAIT. A later md_done returns to RUN; md_err=0.
- MD_TIMEOUT=8 with no md_done → md_err pulses on the 8th MD_WAIT cycle, then state is RUN.
- rst_n low during MD_WAIT → immediate forced reset outputs. After release: RUN, stall_cycles=0, and md_done is ignored.
